// File: rtl/fl_buffer_transmitter_pkg.sv
// ----------------------------------------------------------------------------
// fl_buffer_transmitter_pkg
//
// Shared types for the FrameLink buffer transmitter:
//   tx_state_t    - read-side FSM states (idle, header part, payload part)
//   fl_word_t     - one FL word with its data, REM and active-low delimiters,
//                   carried from the read side through the skid buffer
//   FL_IDLE_WORD  - the value shown on the TX side when nothing is valid
//   SKID_DEPTH    - number of entries in the output skid buffer
//
// fl_word_t is sized by FL_DATA_WIDTH / FL_DREM_WIDTH; the transmitter's
// DATA_WIDTH / DREM_WIDTH parameters must be kept equal to these.
// ----------------------------------------------------------------------------
package fl_buffer_transmitter_pkg;

   localparam int FL_DATA_WIDTH = 64;
   localparam int FL_DREM_WIDTH = 3;
   localparam int SKID_DEPTH    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
   } tx_state_t;

   typedef struct packed {
      logic [FL_DATA_WIDTH-1:0] data;
      logic [FL_DREM_WIDTH-1:0] rem;
      logic                     sofN;
      logic                     eofN;
      logic                     sopN;
      logic                     eopN;
   } fl_word_t;

   localparam fl_word_t FL_IDLE_WORD = '{
      data : '0,
      rem  : '0,
      sofN : 1'b1,
      eofN : 1'b1,
      sopN : 1'b1,
      eopN : 1'b1
   };

endpackage

// File: rtl/fl_tx_skid_buffer.sv
// ----------------------------------------------------------------------------
// fl_tx_skid_buffer
//
// Small register FIFO (SKID_DEPTH entries) that decouples the one-cycle
// memory read pipeline from FL backpressure. The head entry is presented
// with an active-high valid/ready pair; the top converts it to FL polarity.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push         write push_word this cycle
//   push_word    word (data + tags) coming back from the memory read
//   head_word    oldest stored word
//   head_vld     head_word holds a real word
//   head_rdy     consumer takes head_word this cycle when head_vld is high
//   occupancy    number of stored words
// ----------------------------------------------------------------------------
module fl_tx_skid_buffer
   import fl_buffer_transmitter_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  fl_word_t                        push_word,
   output fl_word_t                        head_word,
   output logic                            head_vld,
   input  logic                            head_rdy,
   output logic [$clog2(SKID_DEPTH):0]     occupancy
);

   localparam int PTR_W = $clog2(SKID_DEPTH);

   fl_word_t          entries [SKID_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W:0]    count;
   logic              pop;
   logic              pushOk;

   assign head_vld  = (count != '0);
   assign head_word = entries[rdPtr];
   assign occupancy = count;
   assign pop       = head_vld && head_rdy;

   // The read side only issues reads when there is room, so a push into a
   // full buffer should never happen; it is still refused unless a word is
   // leaving in the same cycle, so stored words can never be overwritten.
   assign pushOk    = push && ((count != (PTR_W+1)'(SKID_DEPTH)) || pop);

   // Storage, pointers and fill count. A push and a pop in the same cycle
   // move both pointers and leave the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            entries[i] <= FL_IDLE_WORD;
         end
      end else begin
         if (pushOk) begin
            entries[wrPtr] <= push_word;
            wrPtr          <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({pushOk, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fl_buffer_transmitter.sv
// ----------------------------------------------------------------------------
// fl_buffer_transmitter
//
// Reads one frame per descriptor from a word-addressed buffer memory and
// sends it out on a FrameLink TX interface. A frame is either two parts
// (header then payload) or, when the header length is zero, payload only.
// Words are tagged with SOF/SOP/EOP/EOF and REM when the read is issued;
// the tags travel with the read data through a two-entry skid buffer.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   desc_addr                first word address of the frame
//   desc_hdr_len             header length in bytes (0 = single-part frame)
//   desc_pay_len             payload length in bytes (0 is treated as 1)
//   desc_vld / desc_rdy      descriptor handshake
//   rd_addr / rd_en          memory read request
//   rd_data                  memory read data, one cycle after rd_en
//   tx_data, tx_rem          FL data word and index of its last valid byte
//   tx_sof_n .. tx_eop_n     FL delimiters, active low
//   tx_src_rdy_n             FL source ready, active low
//   tx_dst_rdy_n             FL destination ready, active low
//   busy                     frame accepted and not yet fully transferred
//   frame_cnt                frames sent (only with FL_BUFFER_TRANSMITTER_FRAME_CNT_EN)
//
// Build option: define FL_BUFFER_TRANSMITTER_FRAME_CNT_EN to add frame_cnt.
// ----------------------------------------------------------------------------
module fl_buffer_transmitter
   import fl_buffer_transmitter_pkg::*;
#(
   parameter int DATA_WIDTH = FL_DATA_WIDTH,
   parameter int DREM_WIDTH = FL_DREM_WIDTH,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] desc_addr,
   input  logic [LEN_WIDTH-1:0]  desc_hdr_len,
   input  logic [LEN_WIDTH-1:0]  desc_pay_len,
   input  logic                  desc_vld,
   output logic                  desc_rdy,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic [DREM_WIDTH-1:0] tx_rem,
   output logic                  tx_sof_n,
   output logic                  tx_eof_n,
   output logic                  tx_sop_n,
   output logic                  tx_eop_n,
   output logic                  tx_src_rdy_n,
   input  logic                  tx_dst_rdy_n,
   output logic                  busy
`ifdef FL_BUFFER_TRANSMITTER_FRAME_CNT_EN
   ,
   output logic [31:0]           frame_cnt
`endif
);

   localparam int BYTES   = DATA_WIDTH / 8;
   localparam int WORDS_W = LEN_WIDTH - DREM_WIDTH + 1;

   tx_state_t             state;
   tx_state_t             nextState;
   logic                  accept;
   logic                  rdEn;
   logic                  canRead;
   logic                  lastOfPart;

   logic                  descRdyQ;
   logic                  descRdyNext;
   logic                  busyQ;
   logic                  busyNext;

   logic [ADDR_WIDTH-1:0] rdAddrQ;
   logic [WORDS_W-1:0]    wordsLeftQ;
   logic [WORDS_W-1:0]    payWordsQ;
   logic [DREM_WIDTH-1:0] hdrRemQ;
   logic [DREM_WIDTH-1:0] payRemQ;
   logic                  hdrZeroQ;
   logic                  firstQ;

   logic [LEN_WIDTH-1:0]  payLenEff;
   logic [LEN_WIDTH:0]    hdrSum;
   logic [LEN_WIDTH:0]    paySum;
   logic [LEN_WIDTH-1:0]  hdrMinus1;
   logic [LEN_WIDTH-1:0]  payMinus1;
   logic [WORDS_W-1:0]    hdrWordsIn;
   logic [WORDS_W-1:0]    payWordsIn;

   logic                  rdValidQ;
   fl_word_t              rdTag;
   fl_word_t              rdTagQ;
   fl_word_t              skidIn;
   fl_word_t              headWord;
   logic                  headVld;
   logic                  headRdy;
   logic                  txXfer;
   logic [1:0]            occ;
   logic [2:0]            used;

   // Descriptor decode: word counts are ceil(len / BYTES) and the REM of a
   // part's last word is (len - 1) mod BYTES. A zero payload length is
   // handled as a one-byte payload so a frame always ends with an EOF word.
   assign payLenEff  = (desc_pay_len == '0) ? LEN_WIDTH'(1) : desc_pay_len;
   assign hdrSum     = {1'b0, desc_hdr_len} + (LEN_WIDTH+1)'(BYTES - 1);
   assign paySum     = {1'b0, payLenEff}    + (LEN_WIDTH+1)'(BYTES - 1);
   assign hdrWordsIn = hdrSum[LEN_WIDTH:DREM_WIDTH];
   assign payWordsIn = paySum[LEN_WIDTH:DREM_WIDTH];
   assign hdrMinus1  = desc_hdr_len - LEN_WIDTH'(1);
   assign payMinus1  = payLenEff - LEN_WIDTH'(1);

   assign lastOfPart = (wordsLeftQ == WORDS_W'(1));

   // Credit check: a new read is allowed while stored words plus the read
   // already in flight, less the word leaving this cycle, stay below the
   // skid depth. Counting the departing word is what gives one word per
   // cycle when the consumer never stalls.
   assign headRdy = !tx_dst_rdy_n;
   assign txXfer  = headVld && headRdy;
   assign used    = {1'b0, occ} + {2'b00, rdValidQ};
   assign canRead = (used < 3'(SKID_DEPTH)) || (txXfer && (used == 3'(SKID_DEPTH)));

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and read strobe. The descriptor is taken only in IDLE once
   // the previous frame has fully left (descRdyQ covers both). Each part
   // moves on as its last read is issued, so the header-to-payload change
   // costs no cycle.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      rdEn      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (desc_vld && descRdyQ) begin
               accept    = 1'b1;
               nextState = (desc_hdr_len != '0) ? ST_HDR : ST_PAY;
            end
         end
         ST_HDR: begin
            if (canRead) begin
               rdEn = 1'b1;
               if (lastOfPart) begin
                  nextState = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            if (canRead) begin
               rdEn = 1'b1;
               if (lastOfPart) begin
                  nextState = ST_IDLE;
               end
            end
         end
         default: begin
            nextState = ST_IDLE;
         end
      endcase
   end

   // Busy runs from descriptor acceptance until the EOF word is handed to
   // the consumer. The ready flag is registered so it stays low in reset and
   // rises one cycle after the frame has gone.
   always_comb begin
      busyNext = busyQ;
      if (txXfer && !headWord.eofN) begin
         busyNext = 1'b0;
      end
      if (accept) begin
         busyNext = 1'b1;
      end
      descRdyNext = (nextState == ST_IDLE) && !busyNext;
   end

   // Tags for the word being read this cycle. Only the first payload word
   // of a payload-only frame carries SOF; header words never carry EOF.
   always_comb begin
      rdTag     = FL_IDLE_WORD;
      rdTag.rem = '1;
      if (state == ST_HDR) begin
         rdTag.sofN = !firstQ;
         rdTag.sopN = !firstQ;
         rdTag.eopN = !lastOfPart;
         if (lastOfPart) begin
            rdTag.rem = hdrRemQ;
         end
      end else begin
         rdTag.sofN = !(firstQ && hdrZeroQ);
         rdTag.sopN = !firstQ;
         rdTag.eopN = !lastOfPart;
         rdTag.eofN = !lastOfPart;
         if (lastOfPart) begin
            rdTag.rem = payRemQ;
         end
      end
   end

   // Read-side datapath: latch the descriptor on accept, then walk the read
   // address (wrapping naturally at the address width) and the per-part word
   // count. The tag of each issued read is held for one cycle so it lines up
   // with the returning memory data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         descRdyQ   <= 1'b0;
         busyQ      <= 1'b0;
         rdAddrQ    <= '0;
         wordsLeftQ <= '0;
         payWordsQ  <= '0;
         hdrRemQ    <= '0;
         payRemQ    <= '0;
         hdrZeroQ   <= 1'b0;
         firstQ     <= 1'b0;
         rdValidQ   <= 1'b0;
         rdTagQ     <= FL_IDLE_WORD;
      end else begin
         descRdyQ <= descRdyNext;
         busyQ    <= busyNext;
         rdValidQ <= rdEn;
         if (rdEn) begin
            rdTagQ <= rdTag;
         end
         if (accept) begin
            rdAddrQ    <= desc_addr;
            payWordsQ  <= payWordsIn;
            hdrRemQ    <= hdrMinus1[DREM_WIDTH-1:0];
            payRemQ    <= payMinus1[DREM_WIDTH-1:0];
            hdrZeroQ   <= (desc_hdr_len == '0);
            firstQ     <= 1'b1;
            wordsLeftQ <= (desc_hdr_len == '0) ? payWordsIn : hdrWordsIn;
         end else if (rdEn) begin
            rdAddrQ <= rdAddrQ + ADDR_WIDTH'(1);
            if ((state == ST_HDR) && lastOfPart) begin
               wordsLeftQ <= payWordsQ;
               firstQ     <= 1'b1;
            end else begin
               wordsLeftQ <= wordsLeftQ - WORDS_W'(1);
               firstQ     <= 1'b0;
            end
         end
      end
   end

   // Merge the returning memory data with its delayed tags.
   always_comb begin
      skidIn      = rdTagQ;
      skidIn.data = rd_data;
   end

   fl_tx_skid_buffer u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (rdValidQ),
      .push_word (skidIn),
      .head_word (headWord),
      .head_vld  (headVld),
      .head_rdy  (headRdy),
      .occupancy (occ)
   );

   // TX side shows the idle word whenever the skid buffer is empty, so stale
   // delimiters from the last frame never appear on the bus.
   always_comb begin
      tx_data      = '0;
      tx_rem       = '0;
      tx_sof_n     = 1'b1;
      tx_eof_n     = 1'b1;
      tx_sop_n     = 1'b1;
      tx_eop_n     = 1'b1;
      tx_src_rdy_n = !headVld;
      if (headVld) begin
         tx_data  = headWord.data;
         tx_rem   = headWord.rem;
         tx_sof_n = headWord.sofN;
         tx_eof_n = headWord.eofN;
         tx_sop_n = headWord.sopN;
         tx_eop_n = headWord.eopN;
      end
   end

   assign rd_en    = rdEn;
   assign rd_addr  = rdAddrQ;
   assign desc_rdy = descRdyQ;
   assign busy     = busyQ;

`ifdef FL_BUFFER_TRANSMITTER_FRAME_CNT_EN
   // Counts frames as their EOF word is transferred; wraps at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (txXfer && !headWord.eofN) begin
         frame_cnt <= frame_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fl_buffer_transmitter.sv
// ----------------------------------------------------------------------------
// tb_fl_buffer_transmitter
//
// Self-checking bench for fl_buffer_transmitter. A memory model answers
// reads one cycle later; expected reads and TX words are built from the
// descriptor with plain arithmetic and compared by a monitor process, while
// each scenario task checks its own timing and counts.
// Define FL_BUFFER_TRANSMITTER_FRAME_CNT_EN to also check frame_cnt.
// ----------------------------------------------------------------------------
module tb_fl_buffer_transmitter;

   localparam int B     = 8;
   localparam int MEMSZ = 1024;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  rem;
      logic        sof;
      logic        eof;
      logic        sop;
      logic        eop;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  desc_addr;
   logic [15:0] desc_hdr_len;
   logic [15:0] desc_pay_len;
   logic        desc_vld;
   logic        desc_rdy;
   logic [9:0]  rd_addr;
   logic        rd_en;
   logic [63:0] rd_data;
   logic [63:0] tx_data;
   logic [2:0]  tx_rem;
   logic        tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n;
   logic        tx_src_rdy_n;
   logic        tx_dst_rdy_n;
   logic        busy;
`ifdef FL_BUFFER_TRANSMITTER_FRAME_CNT_EN
   logic [31:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [63:0] mem [MEMSZ];
   exp_t        expTx [$];
   logic [9:0]  expRd [$];
   logic [9:0]  rdLog [$];
   int          xferCycles [$];
   int          readsIssued = 0;
   int          xfers       = 0;
   int          eofSeen     = 0;

   exp_t        me;
   logic [9:0]  ma;
   logic [70:0] prevVec;
   logic [70:0] curVec;
   bit          stalledPrev = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   fl_buffer_transmitter dut (
      .clk          (clk),
      .reset        (reset),
      .desc_addr    (desc_addr),
      .desc_hdr_len (desc_hdr_len),
      .desc_pay_len (desc_pay_len),
      .desc_vld     (desc_vld),
      .desc_rdy     (desc_rdy),
      .rd_addr      (rd_addr),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .tx_data      (tx_data),
      .tx_rem       (tx_rem),
      .tx_sof_n     (tx_sof_n),
      .tx_eof_n     (tx_eof_n),
      .tx_sop_n     (tx_sop_n),
      .tx_eop_n     (tx_eop_n),
      .tx_src_rdy_n (tx_src_rdy_n),
      .tx_dst_rdy_n (tx_dst_rdy_n),
      .busy         (busy)
`ifdef FL_BUFFER_TRANSMITTER_FRAME_CNT_EN
      ,
      .frame_cnt    (frame_cnt)
`endif
   );

   // Memory model: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Monitor: checks every read address and every transferred word against
   // the expected queues, that stalled outputs hold, and that no more than
   // two words are ever outstanding between read and transfer.
   always @(negedge clk) begin
      if (reset) begin
         stalledPrev = 0;
         readsIssued = 0;
         xfers       = 0;
         eofSeen     = 0;
      end else begin
         curVec = {tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};
         if (rd_en) begin
            checks++;
            rdLog.push_back(rd_addr);
            if (expRd.size() == 0) begin
               errors++;
               $display("[TB] FAIL rd_unexpected: addr=%h, none expected", rd_addr);
            end else begin
               ma = expRd.pop_front();
               if (rd_addr !== ma) begin
                  errors++;
                  $display("[TB] FAIL rd_addr: got %h, expected %h", rd_addr, ma);
               end
            end
            readsIssued++;
         end
         if (!tx_src_rdy_n && stalledPrev) begin
            checks++;
            if (curVec !== prevVec) begin
               errors++;
               $display("[TB] FAIL stall_hold: got %h, expected %h", curVec, prevVec);
            end
         end
         if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
            checks++;
            if (expTx.size() == 0) begin
               errors++;
               $display("[TB] FAIL tx_unexpected: data=%h, none expected", tx_data);
            end else begin
               me = expTx.pop_front();
               if (tx_data !== me.data || tx_rem !== me.rem ||
                   {!tx_sof_n, !tx_eof_n, !tx_sop_n, !tx_eop_n} !== {me.sof, me.eof, me.sop, me.eop}) begin
                  errors++;
                  $display("[TB] FAIL tx_word: got data=%h rem=%0d sof/eof/sop/eop=%b, expected data=%h rem=%0d sof/eof/sop/eop=%b",
                           tx_data, tx_rem, {!tx_sof_n, !tx_eof_n, !tx_sop_n, !tx_eop_n},
                           me.data, me.rem, {me.sof, me.eof, me.sop, me.eop});
               end
            end
            xfers++;
            xferCycles.push_back(cycle);
            if (!tx_eof_n) eofSeen++;
         end
         checks++;
         if (readsIssued - xfers > 2) begin
            errors++;
            $display("[TB] FAIL outstanding: got %0d, expected at most 2", readsIssued - xfers);
         end
         stalledPrev = !tx_src_rdy_n && tx_dst_rdy_n;
         prevVec     = curVec;
      end
   end

   // Reference model: expected reads and words straight from the frame rules.
   task automatic build_expected(input int addr, input int hdr, input int pay);
      int   payEff, nh, np, a;
      exp_t e;
      payEff = (pay == 0) ? 1 : pay;
      nh     = (hdr + B - 1) / B;
      np     = (payEff + B - 1) / B;
      for (int i = 0; i < nh; i++) begin
         a     = (addr + i) % MEMSZ;
         e.data = mem[a];
         e.sof  = (i == 0);
         e.sop  = (i == 0);
         e.eop  = (i == nh - 1);
         e.eof  = 1'b0;
         e.rem  = e.eop ? 3'((hdr - 1) % B) : 3'(B - 1);
         expTx.push_back(e);
         expRd.push_back(10'(a));
      end
      for (int j = 0; j < np; j++) begin
         a     = (addr + nh + j) % MEMSZ;
         e.data = mem[a];
         e.sop  = (j == 0);
         e.sof  = (j == 0) && (hdr == 0);
         e.eop  = (j == np - 1);
         e.eof  = (j == np - 1);
         e.rem  = e.eop ? 3'((payEff - 1) % B) : 3'(B - 1);
         expTx.push_back(e);
         expRd.push_back(10'(a));
      end
   endtask

   task automatic wait_desc_rdy();
      int n = 0;
      forever begin
         @(posedge clk); #1;
         if (desc_rdy) break;
         n++;
         if (n > 2000) begin
            checks++; errors++;
            $display("[TB] FAIL desc_rdy_timeout: got 0, expected 1 within 2000 cycles");
            break;
         end
      end
   endtask

   task automatic applyStimulus(input int addr, input int hdr, input int pay);
      wait_desc_rdy();
      build_expected(addr, hdr, pay);
      desc_addr    = 10'(addr);
      desc_hdr_len = 16'(hdr);
      desc_pay_len = 16'(pay);
      desc_vld     = 1'b1;
      @(posedge clk); #1;
      desc_vld     = 1'b0;
   endtask

   task automatic wait_frame_done();
      int n = 0;
      forever begin
         @(posedge clk); #1;
         if (expTx.size() == 0 && !busy) break;
         n++;
         if (n > 3000) begin
            checks++; errors++;
            $display("[TB] FAIL frame_timeout: got %0d words pending, expected 0", expTx.size());
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [85:0] obs;
      reset        = 1'b1;
      desc_vld     = 1'b0;
      desc_addr    = '0;
      desc_hdr_len = '0;
      desc_pay_len = '0;
      tx_dst_rdy_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {desc_rdy, rd_en, rd_addr, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_data, tx_rem, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 10'h000, 1'b1, 4'hF, 64'h0, 3'h0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h, expected %h", obs, {1'b0, 1'b0, 10'h000, 1'b1, 4'hF, 64'h0, 3'h0, 1'b0});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (desc_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL desc_rdy_after_reset: got %b, expected 1", desc_rdy);
      end
   endtask

   task automatic test_single_part();
      int base = xfers;
      int c0;
      wait_desc_rdy();
      build_expected(16'h010, 0, 64);
      desc_addr = 10'h010; desc_hdr_len = 16'd0; desc_pay_len = 16'd64; desc_vld = 1'b1;
      @(posedge clk); #1;
      desc_vld = 1'b0;
      checks++;
      if ({rd_en, rd_addr, busy} !== {1'b1, 10'h010, 1'b1}) begin
         errors++;
         $display("[TB] FAIL first_read: got rd_en=%b addr=%h busy=%b, expected 1 010 1", rd_en, rd_addr, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (tx_src_rdy_n !== 1'b1) begin
         errors++;
         $display("[TB] FAIL latency_early: got src_rdy_n=%b, expected 1", tx_src_rdy_n);
      end
      @(posedge clk); #1;
      checks++;
      if (tx_src_rdy_n !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency: got src_rdy_n=%b, expected 0", tx_src_rdy_n);
      end
      c0 = xferCycles.size();
      wait_frame_done();
      checks++;
      if (xfers - base !== 8) begin
         errors++;
         $display("[TB] FAIL single_words: got %0d, expected 8", xfers - base);
      end
      checks++;
      if (xferCycles.size() >= c0 + 8 && xferCycles[c0 + 7] - xferCycles[c0] !== 7) begin
         errors++;
         $display("[TB] FAIL single_throughput: got span %0d, expected 7", xferCycles[c0 + 7] - xferCycles[c0]);
      end
   endtask

   task automatic test_two_part();
      int base = xfers;
      int c0   = xferCycles.size();
      applyStimulus(16'h100, 12, 20);
      wait_frame_done();
      checks++;
      if (xfers - base !== 5) begin
         errors++;
         $display("[TB] FAIL two_part_words: got %0d, expected 5", xfers - base);
      end
      checks++;
      if (xferCycles.size() >= c0 + 5 && xferCycles[c0 + 4] - xferCycles[c0] !== 4) begin
         errors++;
         $display("[TB] FAIL two_part_bubble: got span %0d, expected 4", xferCycles[c0 + 4] - xferCycles[c0]);
      end
   endtask

   task automatic test_one_byte_pay();
      int base  = xfers;
      int eBase = eofSeen;
      applyStimulus(16'h200, 8, 1);
      wait_frame_done();
      checks++;
      if ({xfers - base, eofSeen - eBase} !== {32'd2, 32'd1}) begin
         errors++;
         $display("[TB] FAIL one_byte_pay: got words=%0d eofs=%0d, expected 2 1", xfers - base, eofSeen - eBase);
      end
   endtask

   task automatic test_backpressure();
      int base = xfers;
      bit done = 0;
      fork
         begin
            while (!done) begin
               @(posedge clk); #1;
               tx_dst_rdy_n = 1'($urandom_range(0, 1));
            end
         end
         begin
            applyStimulus(int'($urandom_range(0, MEMSZ - 1)), 0, 256);
            wait_frame_done();
            done = 1;
         end
      join
      tx_dst_rdy_n = 1'b0;
      checks++;
      if (xfers - base !== 32) begin
         errors++;
         $display("[TB] FAIL backpressure_words: got %0d, expected 32", xfers - base);
      end
   endtask

   task automatic test_addr_wrap();
      int l0 = rdLog.size();
      applyStimulus(16'h3FE, 0, 32);
      wait_frame_done();
      checks++;
      if (rdLog.size() != l0 + 4) begin
         errors++;
         $display("[TB] FAIL wrap_reads: got %0d reads, expected 4", rdLog.size() - l0);
      end else if ({rdLog[l0], rdLog[l0 + 1], rdLog[l0 + 2], rdLog[l0 + 3]} !== {10'h3FE, 10'h3FF, 10'h000, 10'h001}) begin
         errors++;
         $display("[TB] FAIL wrap_addrs: got %h %h %h %h, expected 3fe 3ff 000 001",
                  rdLog[l0], rdLog[l0 + 1], rdLog[l0 + 2], rdLog[l0 + 3]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int          base = xfers;
      int          n    = 0;
      logic [85:0] obs;
      applyStimulus(16'h080, 0, 64);
      forever begin
         @(posedge clk); #1;
         if (xfers - base >= 3) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("[TB] FAIL mid_frame_timeout: got %0d words, expected 3", xfers - base);
            break;
         end
      end
      reset = 1'b1;
      #1;
      expTx.delete();
      expRd.delete();
      obs = {desc_rdy, rd_en, rd_addr, tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_data, tx_rem, busy};
      checks++;
      if (obs !== {1'b0, 1'b0, 10'h000, 1'b1, 4'hF, 64'h0, 3'h0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL mid_reset_values: got %h, expected %h", obs, {1'b0, 1'b0, 10'h000, 1'b1, 4'hF, 64'h0, 3'h0, 1'b0});
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(16'h020, 0, 16);
      wait_frame_done();
      checks++;
      if ({xfers, eofSeen} !== {32'd2, 32'd1}) begin
         errors++;
         $display("[TB] FAIL after_reset_frame: got words=%0d eofs=%0d, expected 2 1", xfers, eofSeen);
      end
`ifdef FL_BUFFER_TRANSMITTER_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 32'd1) begin
         errors++;
         $display("[TB] FAIL frame_cnt: got %0d, expected 1", frame_cnt);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int  base  = xfers;
      int  eBase = eofSeen;
      int  total = 0;
      int  hdr, pay;
      bit  done  = 0;
      fork
         begin
            while (!done) begin
               @(posedge clk); #1;
               tx_dst_rdy_n = ($urandom_range(0, 3) == 0);
            end
         end
         begin
            for (int k = 0; k < 6; k++) begin
               hdr = int'($urandom_range(0, 40));
               pay = int'($urandom_range(1, 70));
               total += (hdr + B - 1) / B + (pay + B - 1) / B;
               applyStimulus(int'($urandom_range(0, MEMSZ - 1)), hdr, pay);
            end
            wait_frame_done();
            done = 1;
         end
      join
      tx_dst_rdy_n = 1'b0;
      checks++;
      if ({xfers - base, eofSeen - eBase} !== {total, 32'd6}) begin
         errors++;
         $display("[TB] FAIL back_to_back: got words=%0d eofs=%0d, expected %0d 6", xfers - base, eofSeen - eBase, total);
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (expTx.size() != 0 || expRd.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftover: got %0d words %0d reads pending, expected 0 0", expTx.size(), expRd.size());
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < MEMSZ; i++) mem[i] = {$urandom, $urandom};
      test_reset();
      test_single_part();
      test_two_part();
      test_one_byte_pay();
      test_backpressure();
      test_addr_wrap();
      test_back_to_back();
      test_reset_mid_frame();
      checkOutput();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
